switch_allocator: RTL

//  Packet-granular (wormhole) output-port allocator for the AXI-Stream NoC router.

---
 rtl/switch_alloc_pkg.sv | 34 +++
 rtl/alloc_port_fsm.sv | 91 +++++++++
 rtl/switch_allocator.sv | 67 ++++++
 3 files changed

// File: rtl/switch_alloc_pkg.sv
// Shared types and the round-robin pick helper for the wormhole switch allocator.
package switch_alloc_pkg;

  typedef enum logic {ALLOC_IDLE, ALLOC_LOCKED} alloc_state_e;

  // Widest input vector rr_pick handles; callers zero-extend their candidate vector.
  localparam int unsigned MaxIn = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // First set bit of req_vec at or after ptr, wrapping modulo n (ptr < n <= MaxIn).
  function automatic rr_pick_t rr_pick(input logic [MaxIn-1:0] req_vec,
                                       input logic [4:0]       ptr,
                                       input int unsigned      n);
    rr_pick_t   res;
    logic [5:0] idx;
    res = '0;
    for (int unsigned k = 0; k < MaxIn; k++) begin
      if (k < n) begin
        idx = {1'b0, ptr} + 6'(k);
        if (32'(idx) >= n) idx = idx - 6'(n);
        if (!res.found && req_vec[idx[4:0]]) begin
          res.found = 1'b1;
          res.idx   = idx[4:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alloc_port_fsm.sv
// One output port: IDLE/LOCKED lock FSM, round-robin pointer, owner register and
// stall watchdog that force-releases a packet whose owner stops sending beats.
module alloc_port_fsm
  import switch_alloc_pkg::*;
#(
  parameter int unsigned IN_NUM         = 5,
  parameter int unsigned IN_WIDTH       = $clog2(IN_NUM),
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_NUM-1:0]   cand_i,
  input  logic [IN_NUM-1:0]   beat_fire_i,
  input  logic [IN_NUM-1:0]   beat_last_i,
  output logic                busy_o,
  output logic [IN_WIDTH-1:0] owner_o,
  output logic                timeout_o
);

  alloc_state_e             state_q, state_d;
  logic [IN_WIDTH-1:0]      ptr_q, ptr_d;
  logic [IN_WIDTH-1:0]      owner_q, owner_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic                     timeout_q, timeout_d;

  rr_pick_t            pick;
  logic                owner_fire;
  logic                owner_last;
  logic [IN_WIDTH-1:0] owner_next;

  always_comb begin
    pick       = rr_pick(MaxIn'(cand_i), 5'(ptr_q), IN_NUM);
    owner_fire = beat_fire_i[owner_q];
    owner_last = owner_fire && beat_last_i[owner_q];
    owner_next = (owner_q == IN_WIDTH'(IN_NUM - 1)) ? '0 : owner_q + 1'b1;

    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    wd_d      = wd_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ALLOC_IDLE: begin
        if (pick.found) begin
          state_d = ALLOC_LOCKED;
          owner_d = IN_WIDTH'(pick.idx);
          wd_d    = '0;
        end
      end
      ALLOC_LOCKED: begin
        // A last beat on the expiry cycle is a normal release and wins over the watchdog.
        if (owner_last) begin
          state_d = ALLOC_IDLE;
          ptr_d   = owner_next;
        end else if (owner_fire) begin
          wd_d = '0;
        end else if (wd_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ALLOC_IDLE;
          ptr_d     = owner_next;
          timeout_d = 1'b1;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = ALLOC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ALLOC_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy_o    = (state_q == ALLOC_LOCKED);
  assign owner_o   = owner_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/switch_allocator.sv
// Packet-granular output-port allocator: decodes per-output candidate sets, runs one
// lock FSM per output and folds the owners back into per-input grants.
module switch_allocator
  import switch_alloc_pkg::*;
#(
  parameter int unsigned IN_NUM         = 5,
  parameter int unsigned OUT_NUM        = 5,
  parameter int unsigned IN_WIDTH       = $clog2(IN_NUM),
  parameter int unsigned OUT_WIDTH      = $clog2(OUT_NUM),
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_NUM-1:0]             req_valid_i,
  input  logic [IN_NUM*OUT_WIDTH-1:0]   req_port_i,
  input  logic [IN_NUM-1:0]             beat_fire_i,
  input  logic [IN_NUM-1:0]             beat_last_i,
  output logic [IN_NUM-1:0]             grant_o,
  output logic [OUT_NUM*IN_WIDTH-1:0]   grant_sel_o,
  output logic [OUT_NUM-1:0]            out_busy_o,
  output logic [OUT_NUM-1:0]            timeout_o
);

  logic [IN_NUM-1:0]   cand  [OUT_NUM];
  logic [OUT_NUM-1:0]  busy;
  logic [IN_WIDTH-1:0] owner [OUT_NUM];

  // Out-of-range port numbers match no output, so they are simply never granted.
  always_comb begin
    for (int o = 0; o < OUT_NUM; o++) begin
      for (int i = 0; i < IN_NUM; i++) begin
        cand[o][i] = req_valid_i[i] &&
                     (req_port_i[i*OUT_WIDTH +: OUT_WIDTH] == OUT_WIDTH'(o));
      end
    end
  end

  for (genvar o = 0; o < OUT_NUM; o++) begin : g_port
    alloc_port_fsm #(
      .IN_NUM        (IN_NUM),
      .IN_WIDTH      (IN_WIDTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .cand_i     (cand[o]),
      .beat_fire_i(beat_fire_i),
      .beat_last_i(beat_last_i),
      .busy_o     (busy[o]),
      .owner_o    (owner[o]),
      .timeout_o  (timeout_o[o])
    );
    assign grant_sel_o[o*IN_WIDTH +: IN_WIDTH] = owner[o];
  end

  assign out_busy_o = busy;

  always_comb begin
    grant_o = '0;
    for (int o = 0; o < OUT_NUM; o++) begin
      if (busy[o]) grant_o[owner[o]] = 1'b1;
    end
  end

endmodule
